// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush with bubble insertion and a saturating downstream-stall counter.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 69,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o,
  output logic [15:0]       stall_cnt_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;
  logic                xfer_in, xfer_out;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = stall_cnt_q;
    xfer_in     = valid_i & ready_o;
    xfer_out    = valid_o & ready_i;

    // With start_i low every register holds and ready_o/valid_o are both low.
    if (start_i) begin
      if (valid_o && !ready_i && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end

      if (flush_i) begin
        // Bubble insertion: control bits cleared, data payload left in place.
        state_d     = StEmpty;
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (xfer_in) begin
              main_ctrl_d = ctrl_i;
              main_data_d = data_i;
              state_d     = StFull;
            end
          end
          StFull: begin
            if (xfer_in && xfer_out) begin
              main_ctrl_d = ctrl_i;
              main_data_d = data_i;
            end else if (xfer_in && (SKID != 0)) begin
              skid_ctrl_d = ctrl_i;
              skid_data_d = data_i;
              state_d     = StSkid;
            end else if (xfer_out) begin
              state_d = StEmpty;
            end
          end
          StSkid: begin
            if (xfer_out) begin
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
              state_d     = StFull;
            end
          end
          default: state_d = StEmpty;
        endcase
      end
    end
  end

  always_comb begin
    valid_o = start_i & (state_q != StEmpty);
    if (SKID != 0) begin
      ready_o = start_i & (state_q != StSkid);
    end else begin
      ready_o = start_i & (ready_i | (state_q == StEmpty));
    end
    ctrl_o      = valid_o ? main_ctrl_q : '0;
    data_o      = main_data_q;
    stall_cnt_o = stall_cnt_q;
    unique case (state_q)
      StFull:  occupancy_o = 2'd1;
      StSkid:  occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus and are each checked
// every cycle against a queue-based model, plus directed literal expectations.
module tb_pipe_stage_reg;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 69;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, flush = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [CW-1:0] ctrl_i = '0;
  logic [DW-1:0] data_i = '0;

  logic          r1_ready, r1_valid, r0_ready, r0_valid;
  logic [CW-1:0] r1_ctrl, r0_ctrl;
  logic [DW-1:0] r1_data, r0_data;
  logic [1:0]    r1_occ, r0_occ;
  logic [15:0]   r1_stall, r0_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush),
    .valid_i(valid_i), .ready_o(r1_ready), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(r1_valid), .ready_i(ready_i), .ctrl_o(r1_ctrl), .data_o(r1_data),
    .occupancy_o(r1_occ), .stall_cnt_o(r1_stall)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_noskid (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush),
    .valid_i(valid_i), .ready_o(r0_ready), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(r0_valid), .ready_i(ready_i), .ctrl_o(r0_ctrl), .data_o(r0_data),
    .occupancy_o(r0_occ), .stall_cnt_o(r0_stall)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: each stage is a FIFO of accepted beats with capacity 2 (skid) or 1 (no skid).
  beat_t       mq1[$];
  beat_t       mq0[$];
  logic [DW-1:0] md1 = '0, md0 = '0;
  int unsigned ms1 = 0, ms0 = 0;
  bit          v1, rd1, v0, rd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq1.delete(); mq0.delete();
      md1 = '0; md0 = '0; ms1 = 0; ms0 = 0;
    end else if (start) begin
      v1  = mq1.size() > 0;
      rd1 = mq1.size() < 2;
      v0  = mq0.size() > 0;
      rd0 = ready_i || (mq0.size() == 0);
      if (v1 && !ready_i && ms1 < 65535) ms1++;
      if (v0 && !ready_i && ms0 < 65535) ms0++;
      if (flush) begin
        mq1.delete(); mq0.delete();
      end else begin
        if (v1 && ready_i) void'(mq1.pop_front());
        if (valid_i && rd1) mq1.push_back(beat_t'({ctrl_i, data_i}));
        if (v0 && ready_i) void'(mq0.pop_front());
        if (valid_i && rd0) mq0.push_back(beat_t'({ctrl_i, data_i}));
      end
      if (mq1.size() > 0) md1 = mq1[0].d;
      if (mq0.size() > 0) md0 = mq0[0].d;
    end
  end

  logic          ev1, ev0, er1, er0;
  logic [CW-1:0] ec1, ec0;

  always @(negedge clk) begin
    ev1 = start && mq1.size() > 0;
    er1 = start && mq1.size() < 2;
    ec1 = ev1 ? mq1[0].c : '0;
    ev0 = start && mq0.size() > 0;
    er0 = start && (ready_i || mq0.size() == 0);
    ec0 = ev0 ? mq0[0].c : '0;
    chk("model_skid1", {r1_valid, r1_ready, r1_ctrl, r1_data, r1_occ, r1_stall},
        {ev1, er1, ec1, md1, 2'(mq1.size()), 16'(ms1)});
    chk("model_skid0", {r0_valid, r0_ready, r0_ctrl, r0_data, r0_occ, r0_stall},
        {ev0, er0, ec0, md0, 2'(mq0.size()), 16'(ms0)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
  endtask

  initial begin
    #1;
    chk("reset_outputs", {r1_valid, r1_ctrl, r1_data, r1_occ, r1_stall, r1_ready}, '0);
    start = 1'b1;
    #1;
    chk("reset_ready_follows_start", {r1_ready, r0_ready}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream of four beats with downstream always ready.
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'hF, DW'(i));
      step();
      chk($sformatf("stream_beat%0d", i), {r1_valid, r1_ctrl, r1_data, r1_occ, r1_stall},
          {1'b1, 4'hF, DW'(i), 2'd1, 16'd0});
    end
    drive(1'b0, '0, '0);
    step();
    chk("stream_drained", {r1_valid, r1_ctrl, r1_data, r1_occ}, {1'b0, 4'h0, DW'(4), 2'd0});

    // Skid fill and ordered drain.
    ready_i = 1'b0;
    drive(1'b1, 4'h3, DW'('hA0));
    step();
    drive(1'b1, 4'h5, DW'('hB0));
    step();
    chk("skid_full", {r1_occ, r1_ready, r1_valid, r1_ctrl, r1_data, r1_stall},
        {2'd2, 1'b0, 1'b1, 4'h3, DW'('hA0), 16'd1});
    drive(1'b0, '0, '0);
    step();
    chk("skid_held", {r1_occ, r1_data, r1_stall}, {2'd2, DW'('hA0), 16'd2});
    ready_i = 1'b1;
    step();
    chk("skid_drain_b", {r1_occ, r1_valid, r1_ctrl, r1_data}, {2'd1, 1'b1, 4'h5, DW'('hB0)});
    step();
    chk("skid_drain_empty", {r1_occ, r1_valid, r1_stall}, {2'd0, 1'b0, 16'd2});

    // Flush in skid state with a same-cycle incoming beat.
    ready_i = 1'b0;
    drive(1'b1, 4'h1, DW'('hA1));
    step();
    drive(1'b1, 4'h2, DW'('hB1));
    step();
    flush = 1'b1;
    drive(1'b1, 4'h7, DW'('hC0));
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_result", {r1_valid, r1_ctrl, r1_occ, r1_ready}, {1'b0, 4'h0, 2'd0, 1'b1});
    ready_i = 1'b1;
    step();
    step();
    chk("flush_c_dropped", {r1_valid, r1_data, r0_valid}, {1'b0, DW'('hA1), 1'b0});

    // Freeze while full; flush must be ignored while frozen.
    ready_i = 1'b0;
    drive(1'b1, 4'h9, DW'('hD0));
    step();
    drive(1'b0, '0, '0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ready_i = i[0];
      flush = (i == 1);
      step();
      chk($sformatf("freeze_%0d", i), {r1_ready, r1_valid, r1_ctrl, r1_occ, r0_occ},
          {1'b0, 1'b0, 4'h0, 2'd1, 2'd1});
    end
    flush = 1'b0;
    ready_i = 1'b0;
    start = 1'b1;
    #1;
    chk("freeze_resume", {r1_valid, r1_ctrl, r1_data}, {1'b1, 4'h9, DW'('hD0)});

    // Stall counter saturation.
    repeat (65540) step();
    chk("stall_saturated", {r1_stall, r0_stall}, {16'hFFFF, 16'hFFFF});
    repeat (3) step();
    chk("stall_stays_saturated", {r1_stall, r0_stall, r1_data}, {16'hFFFF, 16'hFFFF, DW'('hD0)});

    // Async reset between edges while in skid state.
    drive(1'b1, 4'h6, DW'('hE0));
    step();
    drive(1'b0, '0, '0);
    chk("pre_reset_skid", r1_occ, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_skid1", {r1_valid, r1_ctrl, r1_data, r1_occ, r1_stall, r1_ready},
        {1'b0, 4'h0, DW'(0), 2'd0, 16'd0, 1'b1});
    chk("async_reset_skid0", {r0_valid, r0_ctrl, r0_data, r0_occ, r0_stall},
        {1'b0, 4'h0, DW'(0), 2'd0, 16'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // Single-entry variant: stream, then combinational ready.
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'hF, DW'(i));
      step();
      chk($sformatf("noskid_beat%0d", i), {r0_valid, r0_data, r0_occ}, {1'b1, DW'(i), 2'd1});
    end
    ready_i = 1'b0;
    #1;
    chk("noskid_ready_low", r0_ready, 1'b0);
    ready_i = 1'b1;
    #1;
    chk("noskid_ready_high", r0_ready, 1'b1);
    drive(1'b0, '0, '0);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      start   = ($urandom_range(7) != 0);
      flush   = ($urandom_range(15) == 0);
      ready_i = $urandom_range(1);
      drive(1'($urandom_range(1)), CW'($urandom), DW'({$urandom, $urandom, $urandom}));
      if (r0_occ > 2'd1) chk("noskid_occ_le1", r0_occ, 2'd1);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the generalised successor to the fixed EX/MEM latch. It carries a control field and a data field between any two pipeline stages. It adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush with bubble insertion, and a stall-cycle counter. It is instantiated between the IF/ID, ID/EX, EX/MEM and MEM/WB stages with per-stage field widths.

Parameters:
CTRL_W, 4, width of control field (RegWrite/MemReg/MemRead/MemWrite-style bits); zeroed on bubble.
DATA_W, 69, width of data field (e.g. ALU result 32 + rs2 data 32 + rd addr 5); never zeroed except by reset.
SKID, 1, 1 = 2-entry skid buffer with state-only ready_o; 0 = single entry, ready_o combinational from ready_i.

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  global run enable; 0 freezes the stage
flush_i  input  1  synchronous flush; discards all held and incoming beats
valid_i  input  1  upstream beat valid
ready_o  output  1  stage can accept a beat this cycle
ctrl_i  input  CTRL_W  upstream control field
data_i  input  DATA_W  upstream data field
valid_o  output  1  downstream beat valid
ready_i  input  1  downstream accepts a beat this cycle
ctrl_o  output  CTRL_W  control field of oldest held beat; all-zero when valid_o=0
data_o  output  DATA_W  data field of oldest held beat; holds last value when valid_o=0
occupancy_o  output  2  held beats: 0, 1 or 2
stall_cnt_o  output  16  saturating count of downstream-stall cycles

Behaviour:
- Reset (rst_n_i=0, async): state EMPTY; main and skid entries cleared (ctrl, data = 0); valid_o=0, ctrl_o=0, data_o=0, occupancy_o=0, stall_cnt_o=0. ready_o = start_i (combinational from EMPTY state).
- Beat transfer in: valid_i & ready_o. Beat transfer out: valid_o & ready_i. Both evaluated on the same edge.
- ready_o = start_i & (state != SKID) when SKID=1. ready_o = start_i & (ready_i | ~valid_o) when SKID=0. ready_o never depends on valid_i.
- valid_o = start_i & (state != EMPTY). ctrl_o = valid_o ? main.ctrl : 0. data_o = main.data.
- States, SKID=1; transitions only when start_i=1 and flush_i=0:
  - EMPTY: in → main<=input, go to FULL.
  - FULL: in & out → main<=input, stay in FULL. out only → EMPTY. in only → skid<=input, go to SKID. Neither → hold.
  - SKID: ready_o=0. out → main<=skid, go to FULL. Otherwise hold.
- SKID=0: states EMPTY/FULL only; in → main<=input (also legal while out in the same cycle).
- Order is strictly FIFO: main always holds the older beat.
- Latency: 1 cycle input-to-output when downstream is ready. Throughput is 1 beat/cycle with no bubbles in steady state.
- flush_i=1 at an edge (when start_i=1): state→EMPTY, occupancy_o→0, entry ctrl fields→0, data fields retained. Any same-cycle input beat is dropped. Flush has priority over all transfers.
- start_i=0: all state, entries and stall_cnt_o hold. flush_i is ignored. ready_o=0 and valid_o=0, so no transfer can occur.
- occupancy_o: EMPTY=0, FULL=1, SKID=2. Registered with state.
- stall_cnt_o: increments on each edge where start_i & valid_o & ~ready_i. Saturates at 16'hFFFF, with no wrap. Cleared only by reset.
- Reset asserted mid-operation: immediate return to reset values regardless of clock; held beats are lost.

Test Plan:
1. Reset then stream: release rst_n_i, start_i=1, ready_i=1, drive 4 back-to-back beats data=1..4, ctrl=4'hF → data_o 1..4 on consecutive cycles one cycle after input, valid_o continuous, occupancy_o=1, stall_cnt_o=0.
2. Skid fill: FULL with beat A, ready_i=0, present beat B → next cycle occupancy_o=2, ready_o=0, data_o=A. Then ready_i=1 → A out, then B out, order A,B. stall_cnt_o increments once per held cycle.
3. Flush with incoming beat: SKID state holding A,B, flush_i=1 and valid_i=1 with C → next cycle valid_o=0, ctrl_o=0, occupancy_o=0, ready_o=1. C never appears at the output.
4. Freeze: start_i=0 for 3 cycles while FULL with ready_i toggling → ready_o=0, valid_o=0, occupancy_o and stall_cnt_o unchanged. On start_i=1, the same beat reappears.
5. Saturation: hold ready_i=0 with a valid beat for 65540 cycles → stall_cnt_o=16'hFFFF and stays.
6. Async reset mid-stream: assert rst_n_i between clock edges in SKID state → outputs zero immediately, before the next edge. Repeat scenario 1 with SKID=0: ready_o follows ready_i combinationally and occupancy_o never exceeds 1.
